// File: rtl/cell_pos_reader_pkg.sv
// Shared definitions for the cell position reader: FSM state encoding and
// the layout of the particle-count word stored at cell memory address 0.
package cell_pos_reader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CNT_REQ  = 3'd1,
        CNT_WAIT = 3'd2,
        STREAM   = 3'd3,
        DRAIN    = 3'd4
    } state_e;

    // The particle count is the low ADDR_WIDTH bits of word 0, starting at this bit.
    localparam int COUNT_LSB = 0;

endpackage

// File: rtl/cell_pos_fifo.sv
// Synchronous show-ahead FIFO holding {last, index, data} entries for the
// reader's valid/ready output port. DEPTH must be a power of two.
module cell_pos_fifo #(
    parameter int WIDTH = 105,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush, doPop;

    assign doPush = push_i && (!full_o || pop_i);
    assign doPop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Storage needs no reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) store_q[wrPtr_q] <= data_i;
    end

    assign data_o  = store_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/cell_pos_reader.sv
// Reads a cell's particle count from address 0, then streams particles 1..N
// out of the cell memory through a credit-limited FIFO to a valid/ready port.
module cell_pos_reader
    import cell_pos_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);

    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W   = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
    localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   n_q, n_d;
    logic [ADDR_WIDTH-1:0]   nextAddr_q, nextAddr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rden_q, rden_d;
    logic [READ_LATENCY-1:0] tagValid_q;
    logic [ADDR_WIDTH-1:0]   tagAddr_q [READ_LATENCY];

    logic                    retValid, countHit, pushEn, popEn, canIssue, readsIdle;
    logic [ADDR_WIDTH-1:0]   retAddr, rawN, clampedN;
    logic [OCC_W-1:0]        occupancy;
    logic [ENTRY_W-1:0]      pushEntry, headEntry;
    logic [CNT_W-1:0]        fifoCount;
    logic                    fifoFull, fifoEmpty;

    assign retValid  = tagValid_q[READ_LATENCY-1];
    assign retAddr   = tagAddr_q[READ_LATENCY-1];
    assign countHit  = retValid && (retAddr == '0);
    assign pushEn    = retValid && (retAddr != '0);
    assign popEn     = out_valid && out_ready;
    assign rawN      = mem_q[COUNT_LSB +: ADDR_WIDTH];
    assign clampedN  = (rawN > MAX_N) ? MAX_N : rawN;
    assign readsIdle = !rden_q && (tagValid_q == '0);
    assign pushEntry = {(retAddr == n_q), retAddr, mem_q};

    // Credits count the entry leaving this cycle as freed, so a full-rate
    // stream keeps one entry buffered plus the reads still in the pipe.
    always_comb begin
        occupancy = OCC_W'(fifoCount) - OCC_W'(popEn) + OCC_W'(rden_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            occupancy = occupancy + OCC_W'(tagValid_q[i]);
        end
    end

    assign canIssue = !fifoFull && (occupancy < OCC_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            nextAddr_q <= '0;
            addr_q     <= '0;
            rden_q     <= 1'b0;
            tagValid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tagAddr_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            nextAddr_q    <= nextAddr_d;
            addr_q        <= addr_d;
            rden_q        <= rden_d;
            tagValid_q[0] <= rden_q;
            tagAddr_q[0]  <= addr_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagAddr_q[i]  <= tagAddr_q[i-1];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        nextAddr_d = nextAddr_q;
        addr_d     = addr_q;
        rden_d     = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CNT_REQ;
                    rden_d  = 1'b1;
                    addr_d  = '0;
                end
            end
            CNT_REQ: state_d = CNT_WAIT;
            CNT_WAIT: begin
                if (countHit) begin
                    n_d = clampedN;
                    if (clampedN == '0) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Issue address 1 straight away to save a cycle of first-data latency.
                        state_d    = STREAM;
                        nextAddr_d = ADDR_WIDTH'(1);
                        if (canIssue) begin
                            rden_d     = 1'b1;
                            addr_d     = ADDR_WIDTH'(1);
                            nextAddr_d = ADDR_WIDTH'(2);
                            if (clampedN == ADDR_WIDTH'(1)) state_d = DRAIN;
                        end
                    end
                end
            end
            STREAM: begin
                if (canIssue) begin
                    rden_d     = 1'b1;
                    addr_d     = nextAddr_q;
                    nextAddr_d = nextAddr_q + ADDR_WIDTH'(1);
                    if (nextAddr_q == n_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (readsIdle && fifoEmpty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    cell_pos_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (pushEn),
        .data_i (pushEntry),
        .pop_i  (popEn),
        .data_o (headEntry),
        .count_o(fifoCount),
        .full_o (fifoFull),
        .empty_o(fifoEmpty)
    );

    assign out_valid = !fifoEmpty;
    assign {out_last, out_index, out_data} = out_valid ? headEntry : '0;

    assign busy        = (state_q != IDLE);
    assign mem_address = addr_q;
    assign mem_rden    = rden_q;
    assign mem_wren    = 1'b0;
    assign mem_data    = '0;

endmodule

// File: doc/cell_pos_reader.md
CELL_POS_READER -- requirements
Module: cell_pos_reader

Interface
REQ-001 The parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 96, one memory word, {posz, posy, posx}.
- ADDR_WIDTH, 8, cell memory address width.
- PARTICLE_NUM, 220, words in the cell memory, including address 0.
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 4.

REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic runs on the rising edge.
- rst_n, in, 1, reset, synchronous and active-low.
- start, in, 1, one-cycle request to stream the cell.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse when the stream is complete.
- mem_address, out, ADDR_WIDTH, cell memory address.
- mem_rden, out, 1, cell memory read enable.
- mem_wren, out, 1, cell memory write enable; constant 0.
- mem_data, out, DATA_WIDTH, cell memory write data; constant 0.
- mem_q, in, DATA_WIDTH, cell memory read data.
- out_valid, out, 1, output particle available.
- out_ready, in, 1, consumer accepts the output this cycle.
- out_data, out, DATA_WIDTH, particle {posz, posy, posx}, passed through unmodified.
- out_index, out, ADDR_WIDTH, memory address of the particle (1..N).
- out_last, out, 1, marks the final particle of the cell.

Function
REQ-003 mem_q SHALL be treated as valid exactly 2 cycles after the cycle in which mem_rden=1 was driven.
- Every read SHALL be tagged by a 2-stage valid/address shift register.
- The tag is never inferred from state.
REQ-004 mem_address and mem_rden SHALL be registered outputs.
REQ-005 The FSM SHALL have exactly these states: IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN.
- IDLE: start=1 -> CNT_REQ; busy<=1.
- CNT_REQ: drive address 0 with rden=1 for 1 cycle -> CNT_WAIT.
- CNT_WAIT: when the address-0 tag arrives, capture N = mem_q[ADDR_WIDTH-1:0].
  - If N > PARTICLE_NUM-1, clamp N to PARTICLE_NUM-1.
  - If N = 0: go to IDLE, pulse done, emit no output.
  - Otherwise -> STREAM.
- STREAM: issue reads at addresses 1..N in order; after issuing address N -> DRAIN.
- DRAIN: when no read is in flight and the FIFO is empty: done=1 for 1 cycle, busy<=0 -> IDLE.
REQ-006 Read issue rule: a read SHALL be issued in a cycle only if fifo_count + inflight < FIFO_DEPTH.
- The FIFO therefore never overflows and no returned data is dropped.
REQ-007 Every returned particle word SHALL be pushed into the FIFO together with its index and last flag; last = (index == N).
REQ-008 The output handshake SHALL be valid/ready. A transfer occurs when out_valid and out_ready are both 1.
- out_valid, out_data, out_index and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 With out_ready held at 1, throughput SHALL be 1 particle per cycle. The first out_valid SHALL appear 7 cycles after the cycle in which start is sampled.
REQ-010 start SHALL be ignored while busy=1.
REQ-011 done and a start in the same cycle: start SHALL be ignored, because busy is still 1 in that cycle.
REQ-012 mem_wren SHALL be constant 0 and mem_data SHALL be constant 0.

Reset
REQ-013 When rst_n=0 at a clock edge, the following SHALL be cleared:
- state=IDLE, busy=0, done=0.
- mem_rden=0, mem_address=0.
- out_valid=0, out_index=0, out_last=0, out_data=0.
- FIFO emptied, tags cleared, N=0.
REQ-014 Reset mid-stream SHALL abort the stream with no done pulse.
- Read data returning after reset SHALL be discarded.
- The first start after reset SHALL begin a fresh cell read.

Structure
REQ-015 The following SHALL live in the shared define file, not locally:
- the FSM state encodings;
- the count field position in address 0 (low ADDR_WIDTH bits).
REQ-016 The output buffer SHALL be one sub-module, cell_pos_fifo.
- Synchronous, parameterised width and depth.
- Outputs: count, full, empty.
- Stores {last, index, data}.
REQ-017 The 2-cycle latency model SHALL be a single parameter, so the block can be retargeted to other memory read latencies.

Verification
REQ-018 Memory model N=3, out_ready=1, start pulse: out_index 1,2,3 on 3 consecutive cycles; first valid at start+7; out_last only on index 3; done 1 cycle after the last transfer.
REQ-019 Address 0 = 0: done pulses with no out_valid ever asserted; busy returns to 0.
REQ-020 N=10, out_ready toggling 1010...: all 10 particles delivered in order, no duplicates; data held stable during stalls; fifo_count never exceeds 4.
REQ-021 Address 0 = 0xFF with PARTICLE_NUM=220: N clamped to 219; exactly 219 transfers; last index 219.
REQ-022 rst_n=0 for 1 cycle after the 5th transfer of N=20: no further out_valid and no done; a new start yields indices 1..20 correctly.
REQ-023 start re-pulsed while busy, and start in the done cycle: both ignored; only one stream is produced.
